// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V opcodes, NOP encoding and fetch FSM state type
package riscv_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_HALT   = 7'b1110101;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  function automatic logic is_halt(input logic [31:0] instr);
    return instr[6:0] == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with load, hold and bubble controls
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             bubble,
  input  logic [PC_W-1:0]  pc_in,
  input  logic [INS_W-1:0] instr_in,
  output logic [PC_W-1:0]  pc,
  output logic [INS_W-1:0] instr,
  output logic             valid
);

  // Bubble wins over load so a squash can never be overridden by a fetch.
  always_ff @(posedge clk) begin
    if (!reset || bubble) begin
      pc    <= '0;
      instr <= INS_W'(NOP_INSTR);
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_in;
      instr <= instr_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, RUN/HALTED FSM, IF/ID register; FETCH_PERF_EN adds counters
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int             PC_W     = 9,
  parameter int             INS_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  output logic [PC_W-1:0]  if_id_pc,
  output logic [INS_W-1:0] if_id_instr,
  output logic             if_id_valid,
`ifdef FETCH_PERF_EN
  output logic [31:0]      fetch_count,
  output logic [31:0]      stall_count,
`endif
  output logic             halted
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic            fetch_halt;
  logic            ifid_load;
  logic            ifid_bubble;

  assign imem_addr   = pc;
  assign fetch_halt  = imem_rdata[6:0] == OPC_HALT;
  assign ifid_load   = !flush && !stall && (state == RUN);
  assign ifid_bubble = flush || (!stall && (state == HALTED));

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc     <= RESET_PC;
      state  <= RUN;
      halted <= 1'b0;
    end else if (flush) begin
      pc     <= {branch_target[PC_W-1:2], 2'b00};
      state  <= RUN;
      halted <= 1'b0;
    end else if (!stall && state == RUN) begin
      // HALT parks the PC on itself so a later flush is the only way out.
      if (fetch_halt) begin
        state  <= HALTED;
        halted <= 1'b1;
      end else begin
        pc <= pc + PC_W'(4);
      end
    end
  end

  if_id_reg #(
    .PC_W  (PC_W),
    .INS_W (INS_W)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .pc_in    (pc),
    .instr_in (imem_rdata),
    .pc       (if_id_pc),
    .instr    (if_id_instr),
    .valid    (if_id_valid)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (ifid_load && fetch_count != 32'hFFFF_FFFF)
        fetch_count <= fetch_count + 32'd1;
      if (stall && !flush && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a behavioural fetch model
module tb_fetch_stage;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall;
  logic             flush;
  logic [PC_W-1:0]  branch_target;
  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_rdata;
  logic [PC_W-1:0]  if_id_pc;
  logic [INS_W-1:0] if_id_instr;
  logic             if_id_valid;
  logic             halted;
`ifdef FETCH_PERF_EN
  logic [31:0]      fetch_count;
  logic [31:0]      stall_count;
  logic [31:0]      w_fetch_count;
  logic [31:0]      w_stall_count;
`endif

  logic [PC_W-1:0]  w_imem_addr;
  logic [INS_W-1:0] w_imem_rdata;
  logic [PC_W-1:0]  w_if_id_pc;
  logic [INS_W-1:0] w_if_id_instr;
  logic             w_if_id_valid;
  logic             w_halted;

  logic [31:0] mem [128];

  assign imem_rdata   = mem[imem_addr[PC_W-1:2]];
  assign w_imem_rdata = mem[w_imem_addr[PC_W-1:2]];

  always #5 clk = ~clk;

  fetch_stage #(.PC_W(PC_W), .INS_W(INS_W), .RESET_PC(9'h000)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
`ifdef FETCH_PERF_EN
    .fetch_count   (fetch_count),
    .stall_count   (stall_count),
`endif
    .halted        (halted)
  );

  fetch_stage #(.PC_W(PC_W), .INS_W(INS_W), .RESET_PC(9'h1FC)) dut_wrap (
    .clk           (clk),
    .reset         (reset),
    .stall         (1'b0),
    .flush         (1'b0),
    .branch_target ('0),
    .imem_addr     (w_imem_addr),
    .imem_rdata    (w_imem_rdata),
    .if_id_pc      (w_if_id_pc),
    .if_id_instr   (w_if_id_instr),
    .if_id_valid   (w_if_id_valid),
`ifdef FETCH_PERF_EN
    .fetch_count   (w_fetch_count),
    .stall_count   (w_stall_count),
`endif
    .halted        (w_halted)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model state, byte-address arithmetic on plain ints.
  int          m_pc;
  int          m_ifid_pc;
  logic [31:0] m_ifid_instr;
  bit          m_valid;
  bit          m_halted;
  longint      m_fetches;
  longint      m_stalls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_bubble();
    m_ifid_pc    = 0;
    m_ifid_instr = 32'h00000013;
    m_valid      = 1'b0;
  endtask

  task automatic model_edge(input bit r, input bit s, input bit f, input int bt);
    logic [31:0] w;
    if (!r) begin
      m_pc = 0; m_halted = 0; m_fetches = 0; m_stalls = 0;
      model_bubble();
    end else if (f) begin
      m_pc = bt - (bt % 4);
      m_halted = 0;
      model_bubble();
    end else if (s) begin
      if (m_stalls < 64'hFFFFFFFF) m_stalls++;
    end else if (m_halted) begin
      model_bubble();
    end else begin
      w = mem[m_pc / 4];
      m_ifid_pc    = m_pc;
      m_ifid_instr = w;
      m_valid      = 1'b1;
      if (m_fetches < 64'hFFFFFFFF) m_fetches++;
      if (w[6:0] == 7'h75) m_halted = 1;
      else m_pc = (m_pc + 4) % 512;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},        32'(imem_addr),   32'(m_pc));
    chk({tag, ".if_id_pc"},  32'(if_id_pc),    32'(m_ifid_pc));
    chk({tag, ".instr"},     if_id_instr,      m_ifid_instr);
    chk({tag, ".valid"},     32'(if_id_valid), 32'(m_valid));
    chk({tag, ".halted"},    32'(halted),      32'(m_halted));
`ifdef FETCH_PERF_EN
    chk({tag, ".fetch_cnt"}, fetch_count,      m_fetches[31:0]);
    chk({tag, ".stall_cnt"}, stall_count,      m_stalls[31:0]);
`endif
  endtask

  task automatic step(input string tag, input bit r, input bit s, input bit f, input int bt);
    reset = r; stall = s; flush = f; branch_target = PC_W'(bt);
    @(posedge clk);
    model_edge(r, s, f, bt);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 128; i++) mem[i] = {$urandom_range(0, 32'h1FFFFFF), 7'b0010011};
    reset = 1'b0; stall = 1'b0; flush = 1'b0; branch_target = '0;

    step("reset0", 0, 0, 0, 0);
    step("reset1", 0, 0, 0, 0);
    chk("reset_nop",     if_id_instr,       32'h00000013);
    chk("reset_valid",   32'(if_id_valid),  32'd0);
    chk("wrap_reset_pc", 32'(w_imem_addr),  32'h1FC);

    step("run0", 1, 0, 0, 0);
    chk("wrap_next_pc", 32'(w_imem_addr), 32'h000);
    chk("run0_ifpc",    32'(if_id_pc),    32'h000);
    step("run1", 1, 0, 0, 0);
    chk("run1_pc",      32'(imem_addr),   32'h008);

    for (int i = 0; i < 3; i++) step("stall", 1, 1, 0, 0);
    chk("stall_pc",     32'(imem_addr),   32'h008);
    chk("stall_ifpc",   32'(if_id_pc),    32'h004);
    step("resume", 1, 0, 0, 0);

    step("flush_stall", 1, 1, 1, 'h23);
    chk("flush_pc",     32'(imem_addr),   32'h020);
    chk("flush_valid",  32'(if_id_valid), 32'd0);
    step("after_flush", 1, 0, 0, 0);
    chk("after_flush_ifpc", 32'(if_id_pc), 32'h020);

    mem[4] = 32'h00000075;
    step("to_halt", 1, 0, 1, 'h10);
    step("halt", 1, 0, 0, 0);
    chk("halt_instr",  if_id_instr,    32'h00000075);
    chk("halt_flag",   32'(halted),    32'd1);
    chk("halt_pc",     32'(imem_addr), 32'h010);
    for (int i = 0; i < 3; i++) step("halted", 1, 0, 0, 0);
    chk("halted_bubble", 32'(if_id_valid), 32'd0);
    step("unhalt", 1, 0, 1, 'h40);
    chk("unhalt_flag", 32'(halted), 32'd0);
    step("refetch", 1, 0, 0, 0);
    chk("refetch_ifpc", 32'(if_id_pc), 32'h040);

`ifdef FETCH_PERF_EN
    step("perf_rst", 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("perf_fetch", 1, 0, 0, 0);
    step("perf_stall", 1, 1, 0, 0);
    step("perf_stall", 1, 1, 0, 0);
    step("perf_flush", 1, 0, 1, 0);
    chk("perf_fetches", fetch_count, 32'd5);
    chk("perf_stalls",  stall_count, 32'd2);
    step("perf_rst2", 0, 0, 0, 0);
    chk("perf_zero", fetch_count | stall_count, 32'd0);
`endif

    for (int i = 0; i < 128; i++) begin
      w = $urandom;
      if ($urandom_range(0, 15) == 0) w[6:0] = 7'h75;
      mem[i] = w;
    end
    for (int i = 0; i < 400; i++) begin
      bit r, s, f;
      r = $urandom_range(0, 49) != 0;
      s = $urandom_range(0, 3) == 0;
      f = $urandom_range(0, 9) == 0;
      step("rand", r, s, f, int'($urandom_range(0, 511)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
